// File: rtl/riscv_lsu.sv
// Load/store unit: request/ack memory handshake, byte-lane steering, load extension,
// misalignment check. Define LSU_TIMEOUT_EN to build the access timeout. dbg_state: 0 IDLE, 1 ACCESS, 2 RESP.
module riscv_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [2:0]          RW_type,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_stall,
  output logic                core_done,
  output logic [DATA_W-1:0]   core_rdata,
  output logic [1:0]          core_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic              req_illegal, req_misaligned, timed_out;
  logic [OFF_W-1:0]  req_off, off_q;
  logic [BE_W-1:0]   be_mask;
  logic [2:0]        type_q;
  logic [DATA_W-1:0] lane, load_ext;

  assign req_off = core_addr[OFF_W-1:0];

  // Request decode: doubleword and wu only exist on a 64-bit bus.
  always_comb begin
    req_illegal = (RW_type == 3'b111);
    if (DATA_W == 32 && (RW_type == 3'b011 || RW_type == 3'b110)) req_illegal = 1'b1;
    case (RW_type[1:0])
      2'd0:    begin req_misaligned = 1'b0;            be_mask = BE_W'(1);     end
      2'd1:    begin req_misaligned = core_addr[0];    be_mask = BE_W'(3);     end
      2'd2:    begin req_misaligned = |core_addr[1:0]; be_mask = BE_W'(4'hF); end
      default: begin req_misaligned = |core_addr[2:0]; be_mask = '1;          end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst_n || state != S_ACCESS) wait_cnt <= '0;
    else if (!mem_ack && !timed_out) wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  // No counter built: ACCESS waits for mem_ack indefinitely.
  assign timed_out = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (core_req) state_nxt = (req_illegal || req_misaligned) ? S_RESP : S_ACCESS;
      S_ACCESS: if (mem_ack || timed_out) state_nxt = S_RESP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_stall = ((state == S_IDLE) && core_req) || (state == S_ACCESS);
    dbg_state  = state;
  end

  // Pull the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (type_q)
      3'b000:  load_ext = DATA_W'($signed(lane[7:0]));
      3'b001:  load_ext = DATA_W'($signed(lane[15:0]));
      3'b010:  load_ext = DATA_W'($signed(lane[31:0]));
      3'b100:  load_ext = DATA_W'(lane[7:0]);
      3'b101:  load_ext = DATA_W'(lane[15:0]);
      3'b110:  load_ext = DATA_W'(lane[31:0]);
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_done  <= 1'b0;
      core_rdata <= '0;
      core_err   <= 2'b00;
      type_q     <= 3'b000;
      off_q      <= '0;
    end else begin
      core_done  <= 1'b0;
      core_rdata <= '0;
      core_err   <= 2'b00;
      case (state)
        S_IDLE: if (core_req) begin
          if (req_illegal) begin
            core_done <= 1'b1;
            core_err  <= 2'b11;
          end else if (req_misaligned) begin
            core_done <= 1'b1;
            core_err  <= 2'b01;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= core_we;
            mem_be    <= be_mask << req_off;
            mem_addr  <= {core_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_wdata <= core_wdata << {req_off, 3'b000};
            type_q    <= RW_type;
            off_q     <= req_off;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            core_done  <= 1'b1;
            core_rdata <= mem_we ? '0 : load_ext;
          end else if (timed_out) begin
            mem_req   <= 1'b0;
            core_done <= 1'b1;
            core_err  <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a 32-bit and a 64-bit instance share stimulus; sel picks which one
// receives core_req and whose outputs are observed. Expectations come from a byte-level model.
module tb_riscv_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, sel = 1'b0, we = 1'b0, ack = 1'b0;
  logic [2:0]  rw = 3'b000;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;
  int n_checks = 0, n_fail = 0;

  logic        stall32, done32, mreq32, mwe32, stall64, done64, mreq64, mwe64;
  logic [1:0]  err32, err64, dbg32, dbg64;
  logic [3:0]  be32;
  logic [7:0]  be64;
  logic [31:0] maddr32, maddr64, mwd32, rd32;
  logic [63:0] mwd64, rd64;

  riscv_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst_n(rst), .core_req(req & ~sel), .core_we(we), .RW_type(rw),
    .core_addr(addr), .core_wdata(wdata[31:0]), .core_stall(stall32), .core_done(done32),
    .core_rdata(rd32), .core_err(err32), .mem_req(mreq32), .mem_we(mwe32), .mem_be(be32),
    .mem_addr(maddr32), .mem_wdata(mwd32), .mem_ack(ack), .mem_rdata(rdata[31:0]),
    .dbg_state(dbg32));

  riscv_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) u64 (
    .clk(clk), .rst_n(rst), .core_req(req & sel), .core_we(we), .RW_type(rw),
    .core_addr(addr), .core_wdata(wdata), .core_stall(stall64), .core_done(done64),
    .core_rdata(rd64), .core_err(err64), .mem_req(mreq64), .mem_we(mwe64), .mem_be(be64),
    .mem_addr(maddr64), .mem_wdata(mwd64), .mem_ack(ack), .mem_rdata(rdata),
    .dbg_state(dbg64));

  wire        stall  = sel ? stall64 : stall32;
  wire        done   = sel ? done64  : done32;
  wire        mreq   = sel ? mreq64  : mreq32;
  wire        mwe    = sel ? mwe64   : mwe32;
  wire [1:0]  err    = sel ? err64   : err32;
  wire [1:0]  dbg    = sel ? dbg64   : dbg32;
  wire [7:0]  mbe    = sel ? be64    : {4'h0, be32};
  wire [31:0] maddr  = sel ? maddr64 : maddr32;
  wire [63:0] mwdata = sel ? mwd64   : {32'h0, mwd32};
  wire [63:0] rdat   = sel ? rd64    : {32'h0, rd32};

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: what a byte-addressed memory port should see and return for one access.
  task automatic model(input bit s, input bit w, input logic [2:0] t, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd,
                       output logic [1:0] e_err, output logic [7:0] e_be, output logic [31:0] e_addr,
                       output logic [63:0] e_wd, output logic [63:0] e_rd);
    int size, nb, off;
    logic [63:0] dmask, smask, val;
    size  = 1 << t[1:0];
    nb    = s ? 8 : 4;
    dmask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    smask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    off   = int'(a[2:0]) % nb;
    e_err = 2'b00;
    if (t == 3'b111 || (!s && (size == 8 || t == 3'b110))) e_err = 2'b11;
    else if (int'(a[2:0]) % size != 0) e_err = 2'b01;
    e_be   = 8'(((1 << size) - 1) << off);
    e_addr = a - 32'(off);
    e_wd   = ((wd & dmask) << (8 * off)) & dmask;
    val    = ((rd & dmask) >> (8 * off)) & smask;
    if (!t[2] && val[8 * size - 1]) val = (val | ~smask) & dmask;
    e_rd   = (w || e_err != 2'b00) ? 64'd0 : val;
  endtask

  // driver: one complete access with 'waits' unacknowledged ACCESS cycles
  task automatic access(input bit s, input bit w, input logic [2:0] t, input logic [31:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int waits,
                        output logic [63:0] got, output int stall_cyc);
    logic [1:0] e_err; logic [7:0] e_be; logic [31:0] e_addr; logic [63:0] e_wd, e_rd;
    model(s, w, t, a, wd, rd, e_err, e_be, e_addr, e_wd, e_rd);
    stall_cyc = 0;
    @(negedge clk);
    sel = s; we = w; rw = t; addr = a; wdata = wd; rdata = {$urandom, $urandom}; ack = 1'b0; req = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_on_req: got %b want 1", stall); end
    if (stall === 1'b1) stall_cyc++;
    @(negedge clk);
    if (e_err != 2'b00) begin
      n_checks++; if (done !== 1'b1 || err !== e_err) begin n_fail++; $display("FAIL err_resp t=%b a=%h: done=%b err=%b want done=1 err=%b", t, a, done, err, e_err); end
      n_checks++; if (mreq !== 1'b0) begin n_fail++; $display("FAIL err_no_mem: mem_req=%b want 0", mreq); end
    end else begin
      n_checks++; if (mreq !== 1'b1 || mwe !== w || mbe !== e_be || maddr !== e_addr || mwdata !== e_wd) begin
        n_fail++; $display("FAIL mem_cmd t=%b a=%h: req=%b we=%b be=%h addr=%h wd=%h want 1 %b %h %h %h", t, a, mreq, mwe, mbe, maddr, mwdata, w, e_be, e_addr, e_wd);
      end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done: got %b want 0", done); end
      for (int i = 0; i < waits; i++) begin
        if (stall === 1'b1) stall_cyc++;
        rdata = {$urandom, $urandom};
        @(negedge clk);
        n_checks++; if (mreq !== 1'b1 || done !== 1'b0 || mbe !== e_be) begin n_fail++; $display("FAIL wait_hold %0d: req=%b done=%b be=%h want 1 0 %h", i, mreq, done, mbe, e_be); end
      end
      if (stall === 1'b1) stall_cyc++;
      ack = 1'b1; rdata = rd;
      @(negedge clk);
      ack = 1'b0;
      n_checks++; if (done !== 1'b1 || err !== 2'b00) begin n_fail++; $display("FAIL ack_done: done=%b err=%b want 1 00", done, err); end
      n_checks++; if (mreq !== 1'b0) begin n_fail++; $display("FAIL mem_req_drop: got %b want 0", mreq); end
    end
    n_checks++; if (rdat !== e_rd) begin n_fail++; $display("FAIL load_data t=%b a=%h we=%b: got %h want %h", t, a, w, rdat, e_rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_in_resp: got %b want 0", stall); end
    got = rdat; req = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0]; #1;
      n_checks++; if (mreq !== 1'b0 || mwe !== 1'b0 || mbe !== 8'h0 || maddr !== 32'h0 || mwdata !== 64'h0) begin
        n_fail++; $display("FAIL reset_mem sel=%0d: req=%b we=%b be=%h addr=%h wd=%h want zeros", k, mreq, mwe, mbe, maddr, mwdata);
      end
      n_checks++; if (done !== 1'b0 || rdat !== 64'h0 || err !== 2'b00 || stall !== 1'b0 || dbg !== 2'd0) begin
        n_fail++; $display("FAIL reset_core sel=%0d: done=%b rdata=%h err=%b stall=%b state=%0d want 0 0 00 0 0", k, done, rdat, err, stall, dbg);
      end
    end
    sel = 1'b0; rst = 1'b0;
  endtask

  task automatic test_word_load();
    logic [63:0] got; int sc;
    access(1'b0, 1'b0, 3'b010, 32'h104, 64'h0, 64'hDEADBEEF, 0, got, sc);
    n_checks++; if (got !== 64'hDEADBEEF) begin n_fail++; $display("FAIL word_load: got %h want deadbeef", got); end
  endtask

  task automatic test_byte_loads();
    logic [63:0] got; int sc;
    access(1'b0, 1'b0, 3'b000, 32'h203, 64'h0, 64'h80FF7F01, 1, got, sc);
    n_checks++; if (got !== 64'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", got); end
    access(1'b0, 1'b0, 3'b100, 32'h203, 64'h0, 64'h80FF7F01, 0, got, sc);
    n_checks++; if (got !== 64'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", got); end
  endtask

  task automatic test_half_store();
    logic [63:0] got; int sc;
    access(1'b0, 1'b1, 3'b001, 32'h302, 64'h0000ABCD, 64'hFFFF_FFFF, 3, got, sc);
    n_checks++; if (sc !== 5) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 5", sc); end
  endtask

  task automatic test_misaligned_illegal();
    logic [63:0] got; int sc;
    access(1'b0, 1'b0, 3'b010, 32'h101, 64'h0, 64'h1234_5678, 0, got, sc);
    n_checks++; if (sc !== 1) begin n_fail++; $display("FAIL misaligned_stall: got %0d want 1", sc); end
    access(1'b0, 1'b1, 3'b101, 32'h201, 64'h55, 64'h0, 0, got, sc);
    access(1'b0, 1'b0, 3'b011, 32'h1008, 64'h0, 64'h1, 0, got, sc);
    access(1'b1, 1'b0, 3'b111, 32'h1000, 64'h0, 64'h1, 0, got, sc);
    access(1'b1, 1'b0, 3'b011, 32'h1004, 64'h0, 64'h1, 0, got, sc);
  endtask

  task automatic test_dword();
    logic [63:0] got; int sc;
    access(1'b1, 1'b0, 3'b011, 32'h1008, 64'h0, 64'h8000_0000_0000_0001, 0, got, sc);
    n_checks++; if (got !== 64'h8000_0000_0000_0001) begin n_fail++; $display("FAIL ld64: got %h want 8000000000000001", got); end
    access(1'b1, 1'b0, 3'b110, 32'h1004, 64'h0, 64'h8765_4321_0000_0000, 2, got, sc);
    n_checks++; if (got !== 64'h0000_0000_8765_4321) begin n_fail++; $display("FAIL lwu64: got %h want 0000000087654321", got); end
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; rw = 3'b010; addr = 32'h400; req = 1'b1; ack = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin @(negedge clk); cyc++; seen = (done === 1'b1); end
    n_checks++; if (!seen || cyc !== 6) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles (seen=%b) want 6", cyc, seen); end
    n_checks++; if (err !== 2'b10 || rdat !== 64'h0) begin n_fail++; $display("FAIL timeout_err: err=%b rdata=%h want 10 0", err, rdat); end
    req = 1'b0; ack = 1'b1; rdata = 64'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || mreq !== 1'b0) begin n_fail++; $display("FAIL late_ack: done=%b req=%b want 0 0", done, mreq); end
    end
    ack = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || mreq !== 1'b1) begin n_fail++; $display("FAIL long_wait %0d: done=%b req=%b want 0 1", i, done, mreq); end
    end
    ack = 1'b1; rdata = 64'h1234_5678;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 2'b00 || rdat !== 64'h1234_5678) begin n_fail++; $display("FAIL long_wait_done: done=%b err=%b rdata=%h want 1 00 12345678", done, err, rdat); end
    req = 1'b0;
    @(negedge clk);
`endif
  endtask

  // held request with an always-acking memory: accept, ack, RESP, IDLE, accept ...
  task automatic test_back_to_back();
    @(negedge clk);
    sel = 1'b0; we = 1'b0; rw = 3'b010; addr = 32'h10; rdata = 64'hCAFE_F00D; ack = 1'b1; req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_checks++; if (done !== (k % 3 == 1) || mreq !== (k % 3 == 0)) begin n_fail++; $display("FAIL b2b cycle %0d: done=%b req=%b want %b %b", k, done, mreq, (k % 3 == 1), (k % 3 == 0)); end
      if (k % 3 == 1) begin
        n_checks++; if (rdat !== 64'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_data: got %h want cafef00d", rdat); end
      end
    end
    req = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    sel = 1'b0; we = 1'b0; rw = 3'b010; addr = 32'h500; ack = 1'b0; req = 1'b1;
    @(negedge clk);
    n_checks++; if (mreq !== 1'b1) begin n_fail++; $display("FAIL rst_acc_enter: req=%b want 1", mreq); end
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mreq !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_abandon %0d: req=%b done=%b want 0 0", i, mreq, done); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [63:0] got; int sc;
    logic [31:0] a; logic [2:0] t;
    for (int n = 0; n < 80; n++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~(32'd7 >> (3 - t[1:0]));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, a, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 4), got, sc);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_loads();
    test_half_store();
    test_misaligned_illegal();
    test_dword();
    test_timeout();
    test_back_to_back();
    test_reset_in_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
